// File: rtl/pc_unit.sv
// Fetch program counter for the pipelined RV32I core: sequential/branch/JALR
// next-PC selection, stall, flush and misaligned-target trap, boot cycle, redirect counter.
module pc_unit #(
  parameter int unsigned            WIDTH        = 32,
  parameter logic [WIDTH-1:0]       RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0]       TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned            CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] PC,
  input  logic [1:0]       PCsrc,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic [WIDTH-1:0] jalr_base,
  output logic             flush,
  output logic             misalign,
  output logic [WIDTH-1:0] badaddr,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] badaddr_q, badaddr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] tgt;
  logic             is_redirect;
  logic             tgt_bad;

  // Redirect target; JALR clears bit 0 before the alignment check.
  always_comb begin
    br_tgt      = ex_pc + ImmOp;
    jalr_sum    = jalr_base + ImmOp;
    tgt         = br_tgt;
    is_redirect = 1'b0;
    case (PCsrc)
      2'b01: begin
        tgt         = br_tgt;
        is_redirect = 1'b1;
      end
      2'b10: begin
        tgt         = {jalr_sum[WIDTH-1:1], 1'b0};
        is_redirect = 1'b1;
      end
      default: begin
        tgt         = br_tgt;
        is_redirect = 1'b0;
      end
    endcase
    tgt_bad = (tgt[1:0] != 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;
    badaddr_d  = badaddr_q;
    cnt_d      = cnt_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (is_redirect) begin
          flush_d = 1'b1;
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          if (tgt_bad) begin
            pc_d       = TRAP_VECTOR;
            badaddr_d  = tgt;
            misalign_d = 1'b1;
          end else begin
            pc_d = tgt;
          end
        end else if (fetch_ready) begin
          pc_d = pc_q + WIDTH'(4);
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      badaddr_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      badaddr_q  <= badaddr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fetch_valid  = (state_q == RUN);
  assign PC           = pc_q;
  assign flush        = flush_q;
  assign misalign     = misalign_q;
  assign badaddr      = badaddr_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: boot, stall, branch/JALR redirects, trap, wrap and counter saturation.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        fetch_ready;
  logic [1:0]  PCsrc;
  logic [31:0] ex_pc, ImmOp, jalr_base;

  logic        fetch_valid, flush, misalign;
  logic [31:0] PC, badaddr;
  logic [15:0] redirect_cnt;

  logic        fetch_valid_s, flush_s, misalign_s;
  logic [31:0] PC_s, badaddr_s;
  logic [1:0]  redirect_cnt_s;

  int total = 0;
  int bad   = 0;

  pc_unit dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .PC(PC), .PCsrc(PCsrc), .ex_pc(ex_pc), .ImmOp(ImmOp), .jalr_base(jalr_base),
    .flush(flush), .misalign(misalign), .badaddr(badaddr), .redirect_cnt(redirect_cnt)
  );

  pc_unit #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid_s), .fetch_ready(fetch_ready),
    .PC(PC_s), .PCsrc(PCsrc), .ex_pc(ex_pc), .ImmOp(ImmOp), .jalr_base(jalr_base),
    .flush(flush_s), .misalign(misalign_s), .badaddr(badaddr_s), .redirect_cnt(redirect_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_ready = 1'b0; PCsrc = 2'b00;
    ex_pc = '0; ImmOp = '0; jalr_base = '0;
    #3;
    check("rst_pc", PC, 32'h0);
    check("rst_fv", {31'b0, fetch_valid}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_mis", {31'b0, misalign}, 32'h0);
    check("rst_bad", badaddr, 32'h0);
    check("rst_cnt", {16'b0, redirect_cnt}, 32'h0);
    tick(); tick();
    rst = 1'b0; fetch_ready = 1'b1;
    // BOOT cycle: no fetch, PCsrc ignored
    PCsrc = 2'b01; ex_pc = 32'h80;
    #1;
    check("boot_fv", {31'b0, fetch_valid}, 32'h0);
    tick();
    PCsrc = 2'b00; ex_pc = '0;
    check("boot_pc", PC, 32'h0);
    check("boot_noflush", {31'b0, flush}, 32'h0);
    check("run_fv", {31'b0, fetch_valid}, 32'h1);
    for (int i = 0; i < 16; i++) tick();
    check("run_pc40", PC, 32'h40);

    // Asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    check("arst_pc", PC, 32'h0);
    check("arst_fv", {31'b0, fetch_valid}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("boot2_fv", {31'b0, fetch_valid}, 32'h0);
    tick(); check("seq0", PC, 32'h0);
    check("seq0_fv", {31'b0, fetch_valid}, 32'h1);
    tick(); check("seq4", PC, 32'h4);
    tick(); check("seq8", PC, 32'h8);
    tick(); tick();
    check("pc10", PC, 32'h10);

    // Stall
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall", PC, 32'h10);
    end
    fetch_ready = 1'b1;
    tick(); check("unstall", PC, 32'h14);

    // Branch during stall
    fetch_ready = 1'b0; PCsrc = 2'b01; ex_pc = 32'h20; ImmOp = 32'hFFFF_FFF0;
    tick();
    PCsrc = 2'b00;
    check("br_pc", PC, 32'h10);
    check("br_flush", {31'b0, flush}, 32'h1);
    check("br_mis", {31'b0, misalign}, 32'h0);
    check("br_cnt", {16'b0, redirect_cnt}, 32'h1);
    tick();
    check("br_flush_end", {31'b0, flush}, 32'h0);
    check("br_hold", PC, 32'h10);

    // JALR clears bit 0
    PCsrc = 2'b10; jalr_base = 32'h101; ImmOp = 32'h4;
    tick();
    PCsrc = 2'b00;
    check("jalr_pc", PC, 32'h104);
    check("jalr_mis", {31'b0, misalign}, 32'h0);
    check("jalr_flush", {31'b0, flush}, 32'h1);
    check("jalr_cnt", {16'b0, redirect_cnt}, 32'h2);

    // Misaligned branch target traps
    PCsrc = 2'b01; ex_pc = 32'h8; ImmOp = 32'h2;
    tick();
    PCsrc = 2'b00; fetch_ready = 1'b1;
    check("mis_pc", PC, 32'h100);
    check("mis_bad", badaddr, 32'hA);
    check("mis_pulse", {30'b0, misalign, flush}, 32'h3);
    check("mis_cnt", {16'b0, redirect_cnt}, 32'h3);
    tick();
    check("mis_pulse_end", {30'b0, misalign, flush}, 32'h0);
    check("mis_seq", PC, 32'h104);

    // Wrap at top of address space
    PCsrc = 2'b10; jalr_base = 32'hFFFF_FFF8; ImmOp = 32'h4;
    tick();
    PCsrc = 2'b00;
    check("top_pc", PC, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", PC, 32'h0);
    check("cnt4", {16'b0, redirect_cnt}, 32'h4);
    check("sat_cnt4", {30'b0, redirect_cnt_s}, 32'h3);

    // Reserved PCsrc acts as no redirect
    PCsrc = 2'b11; ex_pc = 32'h500; ImmOp = 32'h0;
    tick();
    check("rsv_pc", PC, 32'h4);
    check("rsv_flush", {31'b0, flush}, 32'h0);
    check("rsv_cnt", {16'b0, redirect_cnt}, 32'h4);

    // Back-to-back redirects, last wins
    PCsrc = 2'b01; ex_pc = 32'h200; ImmOp = 32'h0;
    tick();
    check("b2b1_pc", PC, 32'h200);
    check("b2b1_flush", {31'b0, flush}, 32'h1);
    ex_pc = 32'h300; ImmOp = 32'h10;
    tick();
    PCsrc = 2'b00; fetch_ready = 1'b0;
    check("b2b2_pc", PC, 32'h310);
    check("b2b2_flush", {31'b0, flush}, 32'h1);
    check("b2b_cnt", {16'b0, redirect_cnt}, 32'h6);
    check("sat_cnt", {30'b0, redirect_cnt_s}, 32'h3);
    tick();
    check("b2b_flush_end", {31'b0, flush}, 32'h0);

    // Misaligned JALR target keeps bit 1
    PCsrc = 2'b10; jalr_base = 32'h102; ImmOp = 32'h0;
    tick();
    PCsrc = 2'b00;
    check("jmis_pc", PC, 32'h100);
    check("jmis_bad", badaddr, 32'h102);
    check("jmis_mis", {31'b0, misalign}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
